regfile_wb_arbiter: RTL

- Shares the register file's single write port between two writeback sources: the ALU result path and the memory-load path.
- Each source hands over through a valid/ready handshake into its own one-entry slot. A round-robin arbiter drains one slot per cycle onto registered write-port outputs that drive the register file's write address, data and enable.
- Optionally keeps a 16-bit busy scoreboard, so the issue stage can stall on operands and destinations whose writes are still pending.

---
 rtl/brisc_pkg.sv | 13 +
 rtl/wb_slot.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/brisc_pkg.sv
// Shared constants and types for the writeback path.
// DATA_W/ADDR_W defaults and the writeback source id.
package brisc_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback buffer with valid/ready load side.
// Ports: valid/ready/load_addr/load_data in, drain in, full/addr/data out.
module wb_slot #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid,
    output logic          ready,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          drain,
    output logic          full,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    // A slot being drained this cycle can refill on the same edge.
    assign ready = !full || drain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (valid && ready) begin
            full <= 1'b1;
            addr <= load_addr;
            data <= load_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port
// between the ALU and load writeback paths, plus an optional
// busy scoreboard (enabled by `define REGFILE_SCOREBOARD_EN).
// Ports: alu_*/mem_* valid/ready sources, rf_write_* registered
// write port, rsv_* reservation, chk_*/hazard_* lookups, busy_vec.
module regfile_wb_arbiter
    import brisc_pkg::*;
#(
    parameter int DATA_W = brisc_pkg::DATA_W,
    parameter int ADDR_W = brisc_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_addr,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 rf_write_enable,
    output logic [ADDR_W-1:0]    rf_write_addr,
    output logic [DATA_W-1:0]    rf_write_data,
    input  logic                 rsv_valid,
    input  logic [ADDR_W-1:0]    rsv_addr,
    input  logic [ADDR_W-1:0]    chk_a_addr,
    input  logic [ADDR_W-1:0]    chk_b_addr,
    input  logic [ADDR_W-1:0]    chk_d_addr,
    output logic                 hazard_a,
    output logic                 hazard_b,
    output logic                 hazard_d,
    output logic [2**ADDR_W-1:0] busy_vec
);

    localparam int NREG = 2**ADDR_W;

    logic              alu_full;
    logic              mem_full;
    logic [ADDR_W-1:0] alu_slot_addr;
    logic [ADDR_W-1:0] mem_slot_addr;
    logic [DATA_W-1:0] alu_slot_data;
    logic [DATA_W-1:0] mem_slot_data;
    logic              grant_alu;
    logic              grant_mem;
    wb_src_t           prio;

    wb_slot #(.DW(DATA_W), .AW(ADDR_W)) u_alu_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (alu_valid),
        .ready     (alu_ready),
        .load_addr (alu_addr),
        .load_data (alu_data),
        .drain     (grant_alu),
        .full      (alu_full),
        .addr      (alu_slot_addr),
        .data      (alu_slot_data)
    );

    wb_slot #(.DW(DATA_W), .AW(ADDR_W)) u_mem_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (mem_valid),
        .ready     (mem_ready),
        .load_addr (mem_addr),
        .load_data (mem_data),
        .drain     (grant_mem),
        .full      (mem_full),
        .addr      (mem_slot_addr),
        .data      (mem_slot_data)
    );

    always_comb begin
        grant_alu = alu_full && (!mem_full || prio == SRC_ALU);
        grant_mem = mem_full && (!alu_full || prio == SRC_MEM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            prio            <= SRC_MEM;
        end else begin
            if (grant_alu) begin
                rf_write_enable <= 1'b1;
                rf_write_addr   <= alu_slot_addr;
                rf_write_data   <= alu_slot_data;
            end else if (grant_mem) begin
                rf_write_enable <= 1'b1;
                rf_write_addr   <= mem_slot_addr;
                rf_write_data   <= mem_slot_data;
            end else begin
                rf_write_enable <= 1'b0;
            end
            // Pointer only moves when both sources competed.
            if (alu_full && mem_full) begin
                prio <= grant_alu ? SRC_MEM : SRC_ALU;
            end
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // Clear first, then set, so a same-edge reservation wins.
    always_comb begin
        busy_next = busy;
        if (rf_write_enable) begin
            busy_next[rf_write_addr] = 1'b0;
        end
        if (rsv_valid) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_vec = busy;
    assign hazard_a = busy[chk_a_addr];
    assign hazard_b = busy[chk_b_addr];
    assign hazard_d = busy[chk_d_addr];
`else
    wire unused_sb = ^{rsv_valid, rsv_addr, chk_a_addr,
                       chk_b_addr, chk_d_addr};

    assign busy_vec = {NREG{1'b0}};
    assign hazard_a = 1'b0;
    assign hazard_b = 1'b0;
    assign hazard_d = 1'b0;
`endif

endmodule
